// File: rtl/gpr_wb_arb.sv
// GPR writeback arbiter: ALU/LSU -> single register-file write port, with scoreboard.
// Define GPR_WB_RR_EN for round-robin contention; default is fixed priority with starvation override.
module gpr_wb_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_addr,
  input  logic [31:0] alu_wb_data,
  output logic        alu_wb_ready,
  input  logic        lsu_wb_valid,
  input  logic [4:0]  lsu_wb_addr,
  input  logic [31:0] lsu_wb_data,
  output logic        lsu_wb_ready,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  input  logic        sb_set,
  input  logic [4:0]  sb_set_addr,
  output logic [31:0] sb_busy
);

  logic        grant_alu;
  logic        acc;
  logic [4:0]  acc_addr;
  logic [31:0] acc_data;

  logic        wen_q, wen_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] busy_q, busy_d;

`ifdef GPR_WB_RR_EN
  logic last_alu_q, last_alu_d;

  always_comb begin
    grant_alu = alu_wb_valid & ~lsu_wb_valid;
    if (alu_wb_valid && lsu_wb_valid)
      grant_alu = ~last_alu_q;
  end

  always_comb begin
    last_alu_d = last_alu_q;
    if (acc)
      last_alu_d = alu_wb_ready;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) last_alu_q <= 1'b1;
    else           last_alu_q <= last_alu_d;
  end
`else
  localparam int CW = $clog2(STARVE_MAX + 1) + 1;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    grant_alu = alu_wb_valid & ~lsu_wb_valid;
    if (alu_wb_valid && lsu_wb_valid)
      grant_alu = (cnt_q >= CW'(STARVE_MAX));
  end

  // Saturating count of consecutive denied ALU cycles
  always_comb begin
    cnt_d = '0;
    if (alu_wb_valid && !alu_wb_ready) begin
      if (cnt_q >= CW'(STARVE_MAX)) cnt_d = cnt_q;
      else                          cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
`endif

  assign alu_wb_ready = cpu_rstn & alu_wb_valid & grant_alu;
  assign lsu_wb_ready = cpu_rstn & lsu_wb_valid & ~grant_alu;

  assign acc      = alu_wb_ready | lsu_wb_ready;
  assign acc_addr = alu_wb_ready ? alu_wb_addr : lsu_wb_addr;
  assign acc_data = alu_wb_ready ? alu_wb_data : lsu_wb_data;

  // x0 writes are consumed but never reach the register file
  always_comb begin
    wen_d   = acc && (acc_addr != 5'd0);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wen_d) begin
      waddr_d = acc_addr;
      wdata_d = acc_data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wen_d)
      busy_d[acc_addr] = 1'b0;
    if (sb_set && sb_set_addr != 5'd0)
      busy_d[sb_set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign gpr_wen   = wen_q;
  assign gpr_waddr = waddr_q;
  assign gpr_wdata = wdata_q;
  assign sb_busy   = busy_q;

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Directed vector bench for gpr_wb_arb (default fixed-priority build, STARVE_MAX=4).
module tb_gpr_wb_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        av, lv, ss;
  logic [4:0]  aa, la, sa;
  logic [31:0] ad, ld;
  logic        ar, lr, wen;
  logic [4:0]  wa;
  logic [31:0] wd, busy;

  int n_run = 0;
  int n_fail = 0;

  gpr_wb_arb #(.STARVE_MAX(4)) dut (
    .cpu_clk(clk), .cpu_rstn(rstn),
    .alu_wb_valid(av), .alu_wb_addr(aa), .alu_wb_data(ad), .alu_wb_ready(ar),
    .lsu_wb_valid(lv), .lsu_wb_addr(la), .lsu_wb_data(ld), .lsu_wb_ready(lr),
    .gpr_wen(wen), .gpr_waddr(wa), .gpr_wdata(wd),
    .sb_set(ss), .sb_set_addr(sa), .sb_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        ss;
    logic [4:0]  sa;
    logic        ear;
    logic        elr;
    logic        ewen;
    logic        chk_wa;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic [31:0] ebusy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic a_v, input logic [4:0] a_a, input logic [31:0] a_d,
    input logic l_v, input logic [4:0] l_a, input logic [31:0] l_d,
    input logic s_s, input logic [4:0] s_a,
    input logic e_ar, input logic e_lr, input logic e_wen, input logic c_wa,
    input logic [4:0] e_wa, input logic [31:0] e_wd, input logic [31:0] e_b);
    vec_t v;
    v.av = a_v; v.aa = a_a; v.ad = a_d;
    v.lv = l_v; v.la = l_a; v.ld = l_d;
    v.ss = s_s; v.sa = s_a;
    v.ear = e_ar; v.elr = e_lr; v.ewen = e_wen; v.chk_wa = c_wa;
    v.ewa = e_wa; v.ewd = e_wd; v.ebusy = e_b;
    return v;
  endfunction

  task automatic idle();
    av = 0; aa = 0; ad = 0; lv = 0; la = 0; ld = 0; ss = 0; sa = 0;
  endtask

  initial begin
    logic alu_win;
    idle();
    rstn = 1'b0;
    av = 1'b1; aa = 5'd3; ad = 32'hdead;
    #3;
    chk("rst_alu_ready", {31'b0, ar}, 0);
    chk("rst_wen", {31'b0, wen}, 0);
    chk("rst_waddr", {27'b0, wa}, 0);
    chk("rst_wdata", wd, 0);
    chk("rst_busy", busy, 0);
    idle();
    @(negedge clk);
    rstn = 1'b1;

    // basic traffic and scoreboard
    vq.push_back(mk(1,5,32'h1234, 0,0,0, 0,0, 1,0, 1,1,5,32'h1234, 0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0, 0,1,5,32'h1234, 0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,7, 0,0, 0,1,5,32'h1234, 32'h80));
    vq.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0, 0,1,5,32'h1234, 32'h80));
    vq.push_back(mk(0,0,0, 1,7,32'haaaa, 0,0, 0,1, 1,1,7,32'haaaa, 0));
    vq.push_back(mk(1,0,32'h55, 0,0,0, 0,0, 1,0, 0,0,0,0, 0));
    vq.push_back(mk(1,9,32'h99, 0,0,0, 1,9, 1,0, 1,1,9,32'h99, 32'h200));
    vq.push_back(mk(1,9,32'h100, 0,0,0, 0,0, 1,0, 1,1,9,32'h100, 0));
    // continuous contention: ALU forced every fifth cycle
    for (int i = 0; i < 10; i++) begin
      alu_win = (i == 4) || (i == 9);
      vq.push_back(mk(1,1,32'ha0+i, 1,2,32'hb0+i, 0,0,
                      alu_win, !alu_win, 1, 1,
                      alu_win ? 5'd1 : 5'd2,
                      alu_win ? 32'ha0+i : 32'hb0+i, 0));
    end
    // ALU dropping valid clears the starvation count
    for (int i = 0; i < 2; i++)
      vq.push_back(mk(1,1,32'hc0+i, 1,2,32'hd0+i, 0,0, 0,1, 1,1,2,32'hd0+i, 0));
    vq.push_back(mk(0,0,0, 1,2,32'he0, 0,0, 0,1, 1,1,2,32'he0, 0));
    for (int i = 0; i < 5; i++) begin
      alu_win = (i == 4);
      vq.push_back(mk(1,1,32'hf0+i, 1,2,32'h70+i, 0,0,
                      alu_win, !alu_win, 1, 1,
                      alu_win ? 5'd1 : 5'd2,
                      alu_win ? 32'hf0+i : 32'h70+i, 0));
    end

    foreach (vq[k]) begin
      av = vq[k].av; aa = vq[k].aa; ad = vq[k].ad;
      lv = vq[k].lv; la = vq[k].la; ld = vq[k].ld;
      ss = vq[k].ss; sa = vq[k].sa;
      #2;
      chk($sformatf("v%0d_alu_ready", k), {31'b0, ar}, {31'b0, vq[k].ear});
      chk($sformatf("v%0d_lsu_ready", k), {31'b0, lr}, {31'b0, vq[k].elr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wen", k), {31'b0, wen}, {31'b0, vq[k].ewen});
      if (vq[k].chk_wa) begin
        chk($sformatf("v%0d_waddr", k), {27'b0, wa}, {27'b0, vq[k].ewa});
        chk($sformatf("v%0d_wdata", k), wd, vq[k].ewd);
      end
      chk($sformatf("v%0d_busy", k), busy, vq[k].ebusy);
      @(negedge clk);
    end

    // reset pulse between an acceptance and the edge that would register it
    idle();
    ss = 1; sa = 5'd4;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 32'h10);
    @(negedge clk);
    idle();
    av = 1; aa = 5'd3; ad = 32'h3333; ss = 1; sa = 5'd6;
    #1;
    chk("mid_alu_ready", {31'b0, ar}, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, ar}, 0);
    chk("mid_rst_wen", {31'b0, wen}, 0);
    chk("mid_rst_busy", busy, 0);
    idle();
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_wen", {31'b0, wen}, 0);
    chk("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("post_rst_wen2", {31'b0, wen}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
